// File: rtl/rd_seq_ctrl_pkg.sv
// Shared constants and types for the read-device sequencer: counter-enable
// levels, 3-bit state encoding and the registered control-output bundle.
package rd_seq_ctrl_pkg;

   localparam int CNT_W = 4;

   // Asserted level of each phase-counter enable.
   localparam logic RST_CNT_ENABLE = 1'b1;
   localparam logic CLK_ST2_CNT_EN = 1'b1;
   localparam logic RD_ST_CNT_EN   = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RST  = 3'd1,
      ST_WAIT = 3'd2,
      ST_READ = 3'd3,
      ST_OUT  = 3'd4
   } state_e;

   typedef struct packed {
      logic busy;
      logic dev_rst;
      logic dev_cs;
      logic rd_valid;
      logic rst_cnt_en;
      logic wait_en;
      logic rd_en;
   } ctrl_t;

   // Final count of a phase, truncated to the 4-bit counter width (16 -> 4'hF).
   function automatic logic [CNT_W-1:0] last_count(input int cycles);
      return CNT_W'(cycles - 1);
   endfunction

endpackage

// File: rtl/rd_seq_ctrl_shift_reg.sv
// MSB-first capture register for serial read data: shifts left while shift_en
// is high and clears synchronously on rst.
module rd_shift_reg #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             shift_en,
   input  logic             sdi,
   output logic [WIDTH-1:0] data
);

   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] data_d;

   always_comb begin
      // NOTE: default assignment first so every path drives data_d and no latch is inferred.
      data_d = data_q;
      if (shift_en) begin
         data_d = WIDTH'({data_q, sdi});
      end
   end

   // NOTE: this is a plain register bank, so it takes the reset like any other flop;
   // non-blocking assignment keeps the update order-independent across always_ff blocks.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   assign data = data_q;

endmodule

// File: rtl/rd_seq_ctrl.sv
// Read-device sequencer: RST -> WAIT -> READ -> OUT, timed by an external counter block.
// Optional feature macro: RD_AUTO_REPEAT_EN (OUT handshake with start=1 re-enters WAIT).
module rd_seq_ctrl #(
   parameter int RST_CYCLES  = 10,
   parameter int WAIT_CYCLES = 4,
   parameter int RD_BITS     = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   output logic               busy,
   output logic               dev_rst,
   output logic               dev_cs,
   input  logic               dev_sdi,
   output logic [RD_BITS-1:0] rd_data,
   output logic               rd_valid,
   input  logic               rd_ready,
   output logic               rst_cnt_en,
   output logic               wait_st2_cnt_en,
   output logic               rd_st_cnt_en,
   input  logic [3:0]         rst_cnt,
   input  logic [3:0]         wait_st2_cnt,
   input  logic [3:0]         rd_st_cnt
);

   import rd_seq_ctrl_pkg::*;

   localparam logic [CNT_W-1:0] RST_LAST  = last_count(RST_CYCLES);
   localparam logic [CNT_W-1:0] WAIT_LAST = last_count(WAIT_CYCLES);
   localparam logic [CNT_W-1:0] RD_LAST   = last_count(RD_BITS);

   state_e state_q, state_d;
   ctrl_t  ctrl_q, ctrl_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         ctrl_q  <= '0;
      end else begin
         state_q <= state_d;
         ctrl_q  <= ctrl_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (start) state_d = ST_RST;
         ST_RST:  if (rst_cnt == RST_LAST) state_d = ST_WAIT;
         ST_WAIT: if (wait_st2_cnt == WAIT_LAST) state_d = ST_READ;
         ST_READ: if (rd_st_cnt == RD_LAST) state_d = ST_OUT;
         ST_OUT: begin
            if (ctrl_q.rd_valid && rd_ready) begin
`ifdef RD_AUTO_REPEAT_EN
               state_d = start ? ST_WAIT : ST_IDLE;
`else
               state_d = ST_IDLE;
`endif
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs decode the next state so the registered values line up with state_q.
   always_comb begin
      ctrl_d      = '0;
      ctrl_d.busy = (state_d != ST_IDLE);
      case (state_d)
         ST_RST: begin
            ctrl_d.dev_rst    = 1'b1;
            ctrl_d.rst_cnt_en = RST_CNT_ENABLE;
         end
         ST_WAIT: ctrl_d.wait_en = CLK_ST2_CNT_EN;
         ST_READ: begin
            ctrl_d.dev_cs = 1'b1;
            ctrl_d.rd_en  = RD_ST_CNT_EN;
         end
         ST_OUT:  ctrl_d.rd_valid = 1'b1;
         default: ;
      endcase
   end

   rd_shift_reg #(
      .WIDTH(RD_BITS)
   ) u_shift (
      .clk      (clk),
      .rst      (rst),
      .shift_en (state_q == ST_READ),
      .sdi      (dev_sdi),
      .data     (rd_data)
   );

   assign busy            = ctrl_q.busy;
   assign dev_rst         = ctrl_q.dev_rst;
   assign dev_cs          = ctrl_q.dev_cs;
   assign rd_valid        = ctrl_q.rd_valid;
   assign rst_cnt_en      = ctrl_q.rst_cnt_en;
   assign wait_st2_cnt_en = ctrl_q.wait_en;
   assign rd_st_cnt_en    = ctrl_q.rd_en;

endmodule

// File: tb/tb_rd_seq_ctrl.sv
// Bench for rd_seq_ctrl: default-parameter and boundary-parameter instances side by side,
// each with a stand-in counter block, checked cycle by cycle against a phase-interval model.
module tb_rd_seq_ctrl;

`ifdef RD_AUTO_REPEAT_EN
   localparam bit REPEAT = 1'b1;
`else
   localparam bit REPEAT = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  start, ready, sdi;
   logic [1:0]  busy, dev_rst, dev_cs, valid;
   logic [5:0]  en;
   logic [3:0]  cnt [6];
   logic [7:0]  data0;
   logic [15:0] data1;

   int rr[2], ww[2], bb[2];
   bit act[2];
   int t[2];
   logic [15:0] word[2], exp_data[2];
   logic [15:0] wq[$];
   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   // Stand-in for the parent's counter block: 0 on the first enabled cycle, clear when low.
   always @(posedge clk) begin
      for (int k = 0; k < 6; k++) cnt[k] <= en[k] ? cnt[k] + 4'd1 : 4'd0;
   end

   rd_seq_ctrl #(.RST_CYCLES(10), .WAIT_CYCLES(4), .RD_BITS(8)) u0 (
      .clk(clk), .rst(rst), .start(start[0]), .busy(busy[0]), .dev_rst(dev_rst[0]),
      .dev_cs(dev_cs[0]), .dev_sdi(sdi[0]), .rd_data(data0), .rd_valid(valid[0]),
      .rd_ready(ready[0]), .rst_cnt_en(en[0]), .wait_st2_cnt_en(en[1]), .rd_st_cnt_en(en[2]),
      .rst_cnt(cnt[0]), .wait_st2_cnt(cnt[1]), .rd_st_cnt(cnt[2]));

   rd_seq_ctrl #(.RST_CYCLES(1), .WAIT_CYCLES(1), .RD_BITS(16)) u1 (
      .clk(clk), .rst(rst), .start(start[1]), .busy(busy[1]), .dev_rst(dev_rst[1]),
      .dev_cs(dev_cs[1]), .dev_sdi(sdi[1]), .rd_data(data1), .rd_valid(valid[1]),
      .rd_ready(ready[1]), .rst_cnt_en(en[3]), .wait_st2_cnt_en(en[4]), .rd_st_cnt_en(en[5]),
      .rst_cnt(cnt[3]), .wait_st2_cnt(cnt[4]), .rd_st_cnt(cnt[5]));

   task automatic check_word(input int i, input string tag, input logic [15:0] obs,
                             input logic [15:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL u%0d.%s observed %h expected %h (t=%0d)", i, tag, obs, exp, t[i]);
      end
   endtask

   task automatic check_bit(input int i, input string tag, input logic obs, input logic exp);
      check_word(i, tag, {15'd0, obs}, {15'd0, exp});
   endtask

   // Phase boundaries, in cycles since start was sampled: RST 1..R, WAIT R+1..R+W,
   // READ R+W+1..R+W+B, OUT at R+W+B+1.
   function automatic int rd_first(input int i);
      return rr[i] + ww[i] + 1;
   endfunction

   function automatic int out_t(input int i);
      return rr[i] + ww[i] + bb[i] + 1;
   endfunction

   task automatic pick_word(input int i);
      logic [15:0] mask;
      mask = 16'((32'd1 << bb[i]) - 32'd1);
      if (i == 0 && wq.size() > 0) word[i] = wq.pop_front() & mask;
      else                         word[i] = 16'($urandom) & mask;
   endtask

   task automatic drive_sdi(input int i);
      if (act[i] && t[i] >= rd_first(i) && t[i] < out_t(i))
         sdi[i] = word[i][bb[i] - 1 - (t[i] - rd_first(i))];
      else
         sdi[i] = 1'($urandom);
   endtask

   task automatic model_edge(input int i);
      if (rst) begin
         act[i]      = 1'b0;
         exp_data[i] = '0;
      end else if (!act[i]) begin
         if (start[i]) begin
            act[i] = 1'b1;
            t[i]   = 1;
         end
      end else if (t[i] < out_t(i)) begin
         t[i]++;
         if (t[i] == rd_first(i)) pick_word(i);
         if (t[i] == out_t(i))    exp_data[i] = word[i];
      end else if (ready[i]) begin
         if (REPEAT && start[i]) t[i] = rr[i] + 1;
         else                    act[i] = 1'b0;
      end
   endtask

   task automatic check_outs(input int i);
      bit in_rst, in_wait, in_rd, in_out;
      logic [15:0] obs_data;
      in_rst   = act[i] && t[i] >= 1 && t[i] <= rr[i];
      in_wait  = act[i] && t[i] > rr[i] && t[i] <= rr[i] + ww[i];
      in_rd    = act[i] && t[i] >= rd_first(i) && t[i] < out_t(i);
      in_out   = act[i] && t[i] == out_t(i);
      obs_data = (i == 0) ? {8'd0, data0} : data1;
      check_bit(i, "busy",     busy[i],        act[i]);
      check_bit(i, "dev_rst",  dev_rst[i],     in_rst);
      check_bit(i, "dev_cs",   dev_cs[i],      in_rd);
      check_bit(i, "rd_valid", valid[i],       in_out);
      check_bit(i, "rst_en",   en[3*i],        in_rst);
      check_bit(i, "wait_en",  en[3*i + 1],    in_wait);
      check_bit(i, "rd_en",    en[3*i + 2],    in_rd);
      if (!in_rd)   check_word(i, "rd_data",  obs_data, exp_data[i]);
      if (in_rst)   check_word(i, "rst_cnt",  {12'd0, cnt[3*i]},     16'(t[i] - 1));
      if (in_wait)  check_word(i, "wait_cnt", {12'd0, cnt[3*i + 1]}, 16'(t[i] - rr[i] - 1));
      if (in_rd)    check_word(i, "rd_cnt",   {12'd0, cnt[3*i + 2]}, 16'(t[i] - rd_first(i)));
   endtask

   task automatic step();
      for (int i = 0; i < 2; i++) drive_sdi(i);
      @(posedge clk);
      for (int i = 0; i < 2; i++) model_edge(i);
      #1;
      for (int i = 0; i < 2; i++) check_outs(i);
   endtask

   // Step until instance 0 of the model sits at phase cycle tgt; bounded.
   task automatic run_until(input int tgt);
      int guard = 0;
      while (!(act[0] && t[0] == tgt) && guard < 200) begin
         step();
         guard++;
      end
      if (guard >= 200) begin
         n_err++;
         $display("FAIL timeout waiting for t=%0d observed t=%0d", tgt, t[0]);
      end
   endtask

   initial begin
      rr = '{10, 1};
      ww = '{4, 1};
      bb = '{8, 16};
      act = '{1'b0, 1'b0};
      t = '{0, 0};
      word = '{16'd0, 16'd0};
      exp_data = '{16'd0, 16'd0};
      rst = 1'b1; start = 2'b00; ready = 2'b00; sdi = 2'b00;

      // Reset state
      step(); step();
      rst = 1'b0;
      step();

      // Basic read of 0xA5 with back-pressure; boundary instance starts on the same cycle
      wq.push_back(16'h00A5);
      start = 2'b11; step(); start = 2'b00;
      run_until(out_t(0));
      repeat (5) step();
      ready = 2'b11; step(); ready = 2'b00;
      step(); step();

      // Start pulses during WAIT and READ are ignored
      wq.push_back(16'h005A);
      start = 2'b11; step(); start = 2'b00;
      run_until(12);
      start = 2'b11; step(); start = 2'b00;
      run_until(17);
      start = 2'b11; step(); start = 2'b00;
      ready = 2'b11;
      repeat (20) step();
      ready = 2'b00;

      // Reset during the 4th READ cycle, then a fresh full sequence
      start = 2'b11; step(); start = 2'b00;
      run_until(rd_first(0) + 3);
      rst = 1'b1; step(); rst = 1'b0;
      step();
      start = 2'b11; step(); start = 2'b00;
      ready = 2'b11;
      repeat (30) step();

      // Start held high across handshakes: 0xA5 then 0x3C
      wq.push_back(16'h00A5);
      wq.push_back(16'h003C);
      start = 2'b11; ready = 2'b11;
      repeat (50) step();
      start = 2'b00;
      repeat (30) step();

      // Randomized traffic with occasional resets
      repeat (800) begin
         start = 2'($urandom);
         ready = 2'($urandom);
         rst   = ($urandom_range(63) == 0);
         step();
      end
      rst = 1'b0; start = 2'b00; ready = 2'b11;
      repeat (40) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/rd_seq_ctrl.md
# rd_seq_ctrl

Sequencer for the external read device: it drives the enables of the shared phase counter block (`rst_cnt`, `wait_st2_cnt`, `rd_st_cnt`) and uses the returned counts to time three phases.
- Device reset.
- Stage-2 settle wait.
- Serial read of one data word.

The captured word is presented on a valid/ready output port. The block sits beside the counter block in the parent, and the parent wires the enables and counts point-to-point.

## Interface
Parameters:
- RST_CYCLES, 10, device-reset phase length in cycles (1..16)
- WAIT_CYCLES, 4, stage-2 settle length in cycles (1..16)
- RD_BITS, 8, bits per read word, one bit per cycle (1..16)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin a sequence; sampled only in IDLE
- busy  out  1  high in every state except IDLE
- dev_rst  out  1  device reset, high for the whole RST phase
- dev_cs  out  1  device select, high for the whole READ phase
- dev_sdi  in  1  serial data from the device, sampled every READ cycle
- rd_data  out  RD_BITS  captured word, MSB first
- rd_valid  out  1  rd_data valid
- rd_ready  in  1  consumer accepts rd_data
- rst_cnt_en, wait_st2_cnt_en, rd_st_cnt_en  out  1 each  counter enables; asserted value is the shared constant for each counter
- rst_cnt, wait_st2_cnt, rd_st_cnt  in  4 each  counts returned by the counter block

## Operation
- States: IDLE, RST, WAIT, READ, OUT. All outputs are registered Moore outputs decoded from the state.
- Counter contract:
  - A counter reads 0 on the first cycle its enable is high.
  - It increments once per cycle while the enable is held.
  - It clears whenever the enable is low.
- IDLE -> RST when start=1.
- RST: rst_cnt_en and dev_rst asserted. Exit to WAIT on the cycle where rst_cnt == RST_CYCLES-1.
- WAIT: wait_st2_cnt_en asserted. Exit to READ on the cycle where wait_st2_cnt == WAIT_CYCLES-1.
- READ: rd_st_cnt_en and dev_cs asserted.
  - Each cycle the shift register does `{rd_data[RD_BITS-2:0], dev_sdi}`, so the first sample ends up in the MSB.
  - Exit to OUT on the cycle where rd_st_cnt == RD_BITS-1.
- OUT: rd_valid=1. On rd_valid && rd_ready, go to IDLE (see Configuration for the alternative).
- Phase lengths are exactly RST_CYCLES, WAIT_CYCLES and RD_BITS cycles.
- Count compares are 4-bit. A parameter value of 16 compares against 4'hF. Counter wrap never occurs inside a legal phase.
- rd_data changes only in READ. It is stable while rd_valid=1 and retains the last word in IDLE.
- start while busy=1 is ignored and is not queued.
- rd_ready while rd_valid=0 has no effect.
- rst at any cycle, mid-phase included: the next state is IDLE. The next sequence always begins with a full RST phase.

## Timing
- Reset values: state IDLE; busy, dev_rst, dev_cs, rd_valid and all three enables = 0; rd_data = 0.
- With start sampled high at cycle 0:
  - dev_rst is high for cycles 1..R.
  - WAIT covers R+1..R+W.
  - dev_cs is high for R+W+1..R+W+B.
  - rd_valid rises at cycle 1+R+W+B.
- Handshake at cycle t: rd_valid=0 and busy=0 at t+1.
- Minimum spacing: two sequences are separated by at least one IDLE cycle.
- Between phases, each enable drops for at least one cycle before it can rise again, so every counter starts each phase at 0.
- rd_ready high on the same cycle rd_valid rises: rd_valid is high for exactly one cycle.

## Configuration
- RD_AUTO_REPEAT_EN defined:
  - On the OUT handshake with start=1, the next state is WAIT (no device reset), and another word is read.
  - With start=0, the next state is IDLE.
  - busy stays high across repeats.
- RD_AUTO_REPEAT_EN undefined: the OUT handshake always goes to IDLE, and each word needs a full RST+WAIT.

## Structure
- Shared define file:
  - Counter-enable asserted values: RST_CNT_ENABLE, CLK_ST2_CNT_EN, RD_ST_CNT_EN.
  - State encodings (3-bit) for IDLE/RST/WAIT/READ/OUT.
- One sub-module, rd_shift_reg: RD_BITS-wide shift-left register with shift enable (= READ) and synchronous clear on rst.
- The counter block is instantiated by the parent, not inside this block.

## Test plan
- **Basic read:** defaults, start pulse at cycle 0, dev_sdi serially 0xA5 MSB first.
  - dev_rst high for cycles 1–10, dev_cs high for 15–22.
  - rd_valid at 23 with rd_data=0xA5.
- **Back-pressure:** rd_ready low for 5 cycles after valid.
  - rd_valid and rd_data=0xA5 held stable.
  - rd_ready pulse -> busy=0 the next cycle.
- **Start while busy:** start pulses during WAIT and READ.
  - No restart and no second sequence; exactly one rd_valid.
- **Reset mid-read:** rst at the 4th READ cycle.
  - Next cycle: all outputs 0, enables 0, IDLE.
  - Following start gives a fresh 10-cycle dev_rst.
- **Auto-repeat:** RD_AUTO_REPEAT_EN defined, start held high, words 0xA5 then 0x3C.
  - After the first handshake: WAIT for 4 cycles with no dev_rst, then a second rd_valid with 0x3C.
- **Boundary parameters:** RST_CYCLES=1, WAIT_CYCLES=1, RD_BITS=16, start at cycle 0.
  - rd_st_cnt reaches 15 with no wrap.
  - rd_valid at cycle 19 with all 16 bits correct.
